// File: rtl/zed_input_debounce_if.sv
// Signal bundle between the debouncer and its user: raw pins and clear mask in,
// debounced levels, edge pulses, sticky flags and ready out.
interface zed_input_debounce_if #(
    parameter int unsigned WIDTH = 13
) ();

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] event_clr;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] event_flags;
    logic             ready;

    // Consumer side: drives pins and the clear mask, observes conditioned outputs.
    modport master (
        output din,
        output event_clr,
        input  dout,
        input  rise,
        input  fall,
        input  event_flags,
        input  ready
    );

    // Debouncer side.
    modport slave (
        input  din,
        input  event_clr,
        output dout,
        output rise,
        output fall,
        output event_flags,
        output ready
    );

endinterface

// File: rtl/zed_input_debounce.sv
// Push-button / DIP-switch conditioner: per-bit 2-flop synchronizer followed by a
// consecutive-sample debounce counter, with edge pulses, sticky W1C event flags and a
// post-reset settle window that suppresses events for switches already set at reset.
module zed_input_debounce #(
    parameter int unsigned      WIDTH           = 13,
    parameter int unsigned      DEBOUNCE_CYCLES = 1000000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input logic                 clk_a,
    input logic                 rst_a_n,
    zed_input_debounce_if.slave bus
);

    localparam int unsigned CntW      = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned SettleLen = DEBOUNCE_CYCLES + 2;
    localparam int unsigned SettleW   = $clog2(SettleLen + 1);

    localparam logic [CntW-1:0]    CntLast   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SettleW-1:0] SettleEnd = SettleW'(SettleLen);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    logic [WIDTH-1:0]           dout_q, dout_d;
    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           change;

    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] flags_q, flags_d;

    logic [SettleW-1:0] settle_q, settle_d;
    logic               ready_q, ready_d;

    // Two-stage synchronizer; nothing sits between the stages.
    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.din;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: count consecutive disagreeing samples, accept on the last one.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = '0;
        change = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] != dout_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    dout_d[i] = sync2_q[i];
                    change[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edge pulses are masked by the registered ready, so a change landing on the very
    // edge where ready rises is still treated as part of the settle window.
    always_comb begin
        rise_d  = change & dout_d & {WIDTH{ready_q}};
        fall_d  = change & ~dout_d & {WIDTH{ready_q}};
        // Set dominates clear for a bit that has both in the same cycle.
        flags_d = (flags_q & ~bus.event_clr) | rise_q | fall_q;
    end

    // Settle window: count edges after reset, then latch ready until the next reset.
    always_comb begin
        settle_d = settle_q;
        ready_d  = ready_q;
        if (settle_q != SettleEnd) begin
            settle_d = settle_q + 1'b1;
        end
        if (settle_d == SettleEnd) begin
            ready_d = 1'b1;
        end
    end

    // Debounce state, pulses, flags and settle state.
    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            dout_q   <= RESET_VALUE;
            cnt_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            flags_q  <= '0;
            settle_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            flags_q  <= flags_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.rise        = rise_q;
    assign bus.fall        = fall_q;
    assign bus.event_flags = flags_q;
    assign bus.ready       = ready_q;

    // A bit cannot rise and fall at once, and no pulses appear before ready.
    a_pulse_exclusive : assert property (@(posedge clk_a) disable iff (!rst_a_n)
        (rise_q & fall_q) == '0);
    a_no_pulse_unready : assert property (@(posedge clk_a) disable iff (!rst_a_n)
        !ready_q |-> (rise_q == '0 && fall_q == '0));

    // Counters saturate at the acceptance point and never wrap.
    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cnt_bound
        a_cnt_bound : assert property (@(posedge clk_a) disable iff (!rst_a_n)
            cnt_q[g] <= CntLast);
    end

endmodule

// File: tb/tb_zed_input_debounce.sv
// Self-checking bench for zed_input_debounce with DEBOUNCE_CYCLES=8: tasks drive pins and
// push expected rise/fall pulses with their arrival cycle; a monitor pops and compares.
module tb_zed_input_debounce;

    localparam int unsigned W   = 13;
    localparam int unsigned DC  = 8;
    localparam int          LAT = DC + 2;

    typedef struct packed {
        int           cyc;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    logic clk_a   = 1'b0;
    logic rst_a_n = 1'b0;
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;
    exp_t sb[$];

    zed_input_debounce_if #(.WIDTH(W)) bus ();

    zed_input_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .RESET_VALUE    ('0)
    ) dut (
        .clk_a  (clk_a),
        .rst_a_n(rst_a_n),
        .bus    (bus.slave)
    );

    always #5 clk_a = ~clk_a;

    // Rising-edge count; tasks and monitor read it on the falling edge.
    always @(posedge clk_a) cyc++;

    // Pulse monitor: every rise/fall activity must match the head of the scoreboard.
    always @(negedge clk_a) begin
        exp_t e;
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: expected at cycle %0d rise=%h fall=%h, not observed by cycle %0d",
                     e.cyc, e.rise, e.fall, cyc);
        end
        if ((bus.rise | bus.fall) != '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d rise=%h fall=%h, required none",
                         cyc, bus.rise, bus.fall);
            end else begin
                e = sb.pop_front();
                if (e.cyc !== cyc || e.rise !== bus.rise || e.fall !== bus.fall) begin
                    errors++;
                    $display("FAIL pulse: got cycle %0d rise=%h fall=%h, required cycle %0d rise=%h fall=%h",
                             cyc, bus.rise, bus.fall, e.cyc, e.rise, e.fall);
                end
            end
        end
    end

    // Advance n rising edges and land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_a);
        @(negedge clk_a);
    endtask

    task automatic expect_pulse(input int at, input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t e;
        e.cyc  = at;
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        int base;
        bus.din       = 13'h0100;
        bus.event_clr = '0;
        rst_a_n       = 1'b0;
        step(3);
        checks++;
        if (bus.dout !== '0 || bus.ready !== 1'b0 || bus.event_flags !== '0 ||
            bus.rise !== '0 || bus.fall !== '0) begin
            errors++;
            $display("FAIL reset_state: dout=%h ready=%b flags=%h rise=%h fall=%h, required all 0",
                     bus.dout, bus.ready, bus.event_flags, bus.rise, bus.fall);
        end
        rst_a_n = 1'b1;
        base = cyc;
        step(LAT - 1);
        checks++;
        if (bus.dout !== '0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL settle_early: dout=%h ready=%b at edge %0d, required 0000/0",
                     bus.dout, bus.ready, cyc - base);
        end
        step(1);
        checks++;
        if (bus.dout !== 13'h0100 || bus.ready !== 1'b1 || bus.event_flags !== '0) begin
            errors++;
            $display("FAIL settle_done: dout=%h ready=%b flags=%h, required 0100/1/0000",
                     bus.dout, bus.ready, bus.event_flags);
        end
    endtask

    task automatic test_rise;
        int base;
        bus.din = 13'h0101;
        base = cyc;
        expect_pulse(base + LAT, 13'h0001, '0);
        step(LAT - 1);
        checks++;
        if (bus.dout !== 13'h0100) begin
            errors++;
            $display("FAIL rise_early: dout=%h, required 0100", bus.dout);
        end
        step(1);
        checks++;
        if (bus.dout !== 13'h0101) begin
            errors++;
            $display("FAIL rise_latency: dout=%h, required 0101", bus.dout);
        end
        step(1);
        checks++;
        if (bus.rise !== '0 || bus.event_flags !== 13'h0001) begin
            errors++;
            $display("FAIL rise_flag: rise=%h flags=%h, required 0000/0001",
                     bus.rise, bus.event_flags);
        end
    endtask

    task automatic test_glitch;
        int lens[3] = '{1, 3, 7};
        foreach (lens[k]) begin
            bus.din[1] = 1'b1;
            step(lens[k]);
            bus.din[1] = 1'b0;
            step(2);
        end
        step(LAT + 2);
        checks++;
        if (bus.dout[1] !== 1'b0 || bus.event_flags[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch: dout[1]=%b flags[1]=%b, required 0/0",
                     bus.dout[1], bus.event_flags[1]);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        bus.din[2]  = 1'b1;
        bus.din[12] = 1'b1;
        expect_pulse(cyc + LAT, 13'h1004, '0);
        step(LAT + 2);
        checks++;
        if (bus.dout !== 13'h1105) begin
            errors++;
            $display("FAIL multi_rise: dout=%h, required 1105", bus.dout);
        end
        bus.din[2]  = 1'b0;
        bus.din[12] = 1'b0;
        base = cyc;
        expect_pulse(base + LAT, '0, 13'h1004);
        step(LAT - 1);
        checks++;
        if (bus.dout !== 13'h1105) begin
            errors++;
            $display("FAIL multi_fall_early: dout=%h, required 1105", bus.dout);
        end
        step(1);
        checks++;
        if (bus.dout !== 13'h0101 || bus.fall !== 13'h1004) begin
            errors++;
            $display("FAIL multi_fall: dout=%h fall=%h, required 0101/1004", bus.dout, bus.fall);
        end
        step(2);
        checks++;
        if (bus.event_flags !== 13'h1005) begin
            errors++;
            $display("FAIL multi_flags: flags=%h, required 1005", bus.event_flags);
        end
    endtask

    task automatic test_clear;
        bus.din[0] = 1'b0;
        expect_pulse(cyc + LAT, '0, 13'h0001);
        step(LAT + 2);
        bus.din[0] = 1'b1;
        expect_pulse(cyc + LAT, 13'h0001, '0);
        step(LAT);
        // rise[0] is visible now; clear lands on the same edge that would set it
        bus.event_clr = 13'h0001;
        step(1);
        bus.event_clr = '0;
        checks++;
        if (bus.event_flags !== 13'h1005) begin
            errors++;
            $display("FAIL set_beats_clear: flags=%h, required 1005", bus.event_flags);
        end
        step(2);
        bus.event_clr = 13'h0001;
        step(1);
        bus.event_clr = '0;
        checks++;
        if (bus.event_flags !== 13'h1004) begin
            errors++;
            $display("FAIL clear_one: flags=%h, required 1004", bus.event_flags);
        end
        bus.event_clr = 13'h1fff;
        step(1);
        bus.event_clr = '0;
        checks++;
        if (bus.event_flags !== '0) begin
            errors++;
            $display("FAIL clear_all: flags=%h, required 0000", bus.event_flags);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        bus.din[3] = 1'b1;
        step(7);
        rst_a_n = 1'b0;
        #1;
        checks++;
        if (bus.dout !== '0 || bus.event_flags !== '0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: dout=%h flags=%h ready=%b, required 0000/0000/0",
                     bus.dout, bus.event_flags, bus.ready);
        end
        step(2);
        rst_a_n = 1'b1;
        base = cyc;
        step(LAT - 1);
        checks++;
        if (bus.dout !== '0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL resettle_early: dout=%h ready=%b, required 0000/0", bus.dout, bus.ready);
        end
        step(1);
        checks++;
        if (bus.dout !== 13'h0109 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL resettle_done: dout=%h ready=%b, required 0109/1", bus.dout, bus.ready);
        end
        step(3);
        checks++;
        if (bus.event_flags !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL resettle_quiet: flags=%h pending=%0d, required 0000/0",
                     bus.event_flags, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
